// File: rtl/pcie_rx_bar4_buffer.sv
// pcie_rx_bar4_buffer: store-and-forward buffer for BAR4-only TLPs
// tapped off the PCIe RX stream and forwarded to an Ethernet encapsulator.
module pcie_rx_bar4_buffer #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int DEPTH_LOG2   = 9
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    pcie_rx_tready,
  input  logic                    pcie_rx_tvalid,
  input  logic                    pcie_rx_tlast,
  input  logic [KEEP_WIDTH-1:0]   pcie_rx_tkeep,
  input  logic [C_DATA_WIDTH-1:0] pcie_rx_tdata,
  input  logic [21:0]             pcie_rx_tuser,
  input  logic                    eth_tx_tready,
  output logic                    eth_tx_tvalid,
  output logic                    eth_tx_tlast,
  output logic [KEEP_WIDTH-1:0]   eth_tx_tkeep,
  output logic [C_DATA_WIDTH-1:0] eth_tx_tdata,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             drop_cnt
);
  localparam int EW    = C_DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DISCARD
  } wr_state_t;

  wr_state_t state;

  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fetch_ptr;
  logic [PW-1:0] wr_inc;

  logic          beat;
  logic          bar4_only;
  logic          err_fwd;
  logic          full;
  logic          take;
  logic          bad;
  logic          wr_en;
  logic [EW-1:0] wr_entry;

  logic          unused_tuser;

  assign unused_tuser = ^{pcie_rx_tuser[21:7],
                          pcie_rx_tuser[5],
                          pcie_rx_tuser[3],
                          pcie_rx_tuser[0]};

  assign beat      = pcie_rx_tvalid & pcie_rx_tready;
  assign bar4_only = pcie_rx_tuser[6]
                   & ~pcie_rx_tuser[4]
                   & ~pcie_rx_tuser[2];
  assign err_fwd   = pcie_rx_tuser[1];
  assign wr_inc    = wr_ptr + PW'(1);

  // rd_ptr only moves on downstream handshake, so beats sitting in
  // the output pipeline still occupy their slots.
  assign full = wr_inc[DEPTH_LOG2-1:0]
             == rd_ptr[DEPTH_LOG2-1:0];

  assign take  = beat
               & (((state == IDLE) & bar4_only)
               |  (state == CAPTURE));
  assign bad   = full | err_fwd;
  assign wr_en = take & ~bad;

  assign wr_entry = {pcie_rx_tlast,
                     pcie_rx_tkeep,
                     pcie_rx_tdata};

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else if (beat) begin
      unique case (state)
        IDLE, CAPTURE: begin
          if ((state == IDLE) && !bar4_only) begin
            state <= pcie_rx_tlast ? IDLE : DISCARD;
          end else if (bad) begin
            wr_ptr   <= commit_ptr;
            drop_cnt <= drop_cnt + 32'd1;
            state    <= pcie_rx_tlast ? IDLE : DISCARD;
          end else begin
            wr_ptr <= wr_inc;
            if (pcie_rx_tlast) begin
              commit_ptr <= wr_inc;
              pkt_cnt    <= pkt_cnt + 32'd1;
              state      <= IDLE;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        DISCARD: begin
          if (pcie_rx_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_entry;
  end

  logic          avail;
  logic          mem_v;
  logic          mem_to_out;
  logic          issue;
  logic          out_v;
  logic [EW-1:0] mem_q;

  // Two-stage read: registered RAM output feeding the output register,
  // so a stall never loses the beat already fetched.
  assign avail      = fetch_ptr != commit_ptr;
  assign mem_to_out = mem_v & (~out_v | eth_tx_tready);
  assign issue      = avail & (~mem_v | mem_to_out);

  always_ff @(posedge user_clk) begin
    if (issue) mem_q <= mem[fetch_ptr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      fetch_ptr    <= '0;
      rd_ptr       <= '0;
      mem_v        <= 1'b0;
      out_v        <= 1'b0;
      eth_tx_tlast <= 1'b0;
    end else begin
      if (issue) fetch_ptr <= fetch_ptr + PW'(1);
      if (out_v & eth_tx_tready) rd_ptr <= rd_ptr + PW'(1);
      mem_v <= issue | (mem_v & ~mem_to_out);
      if (mem_to_out) begin
        out_v        <= 1'b1;
        eth_tx_tlast <= mem_q[EW-1];
      end else if (eth_tx_tready) begin
        out_v        <= 1'b0;
        eth_tx_tlast <= 1'b0;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (mem_to_out) {eth_tx_tkeep, eth_tx_tdata} <= mem_q[EW-2:0];
  end

  assign eth_tx_tvalid = out_v;

endmodule

// File: doc/pcie_rx_bar4_buffer.md
PCIE_RX_BAR4_BUFFER -- requirements
Module: pcie_rx_bar4_buffer

Interface
REQ-001 Parameter C_DATA_WIDTH, default 64; AXIS data width; only 64 is supported.
REQ-002 Parameter KEEP_WIDTH, default C_DATA_WIDTH/8; byte-enable width.
REQ-003 Parameter DEPTH_LOG2, default 9; buffer holds 2^DEPTH_LOG2 beats.
REQ-004 user_clk  input  1  single clock for all logic.
REQ-005 user_reset  input  1  synchronous, active-high reset.
REQ-006 pcie_rx_tready  input  1  tap-side ready from the RX splitter; the block cannot backpressure it.
REQ-007 pcie_rx_tvalid  input  1  tap beat valid.
REQ-008 pcie_rx_tlast  input  1  last beat of a TLP.
REQ-009 pcie_rx_tkeep  input  KEEP_WIDTH  byte enables.
REQ-010 pcie_rx_tdata  input  C_DATA_WIDTH  TLP data.
REQ-011 pcie_rx_tuser  input  22  core sideband: [1] err_fwd, [2] BAR0 hit, [4] BAR2 hit, [6] BAR4 hit.
REQ-012 eth_tx_tready  input  1  downstream Ethernet encapsulator ready.
REQ-013 eth_tx_tvalid  output  1  buffered beat valid.
REQ-014 eth_tx_tlast  output  1  last beat of buffered TLP.
REQ-015 eth_tx_tkeep  output  KEEP_WIDTH  buffered byte enables.
REQ-016 eth_tx_tdata  output  C_DATA_WIDTH  buffered TLP data.
REQ-017 pkt_cnt  output  32  TLPs committed since reset; wraps at 2^32.
REQ-018 drop_cnt  output  32  BAR4 TLPs discarded since reset; wraps at 2^32.

Function
REQ-019 An input beat SHALL be accepted only when pcie_rx_tvalid and pcie_rx_tready are both 1.
REQ-020 The first accepted beat after reset, and every accepted beat following an accepted tlast beat, SHALL be treated as SOP.
REQ-021 The write FSM SHALL have states IDLE, CAPTURE and DISCARD; reset state is IDLE.
REQ-022 IDLE, SOP with tuser[6:2] BAR bits {6,4,2} == 3'b100 and tuser[1]==0: the beat SHALL be written and the FSM SHALL go to CAPTURE (or stay IDLE and commit if tlast).
REQ-023 IDLE, SOP not hitting only BAR4: the beat SHALL not be written, and the FSM SHALL go to DISCARD unless tlast; drop_cnt SHALL not increment.
REQ-024 CAPTURE: each accepted beat SHALL be written at the speculative write pointer; on tlast the commit pointer SHALL take the new write pointer, pkt_cnt SHALL increment, and the FSM SHALL return to IDLE.
REQ-025 An accepted BAR4 beat that would overflow the buffer (wr_ptr+1 == rd_ptr modulo depth) or that has tuser[1]==1 SHALL abort the TLP: the write pointer reverts to the commit pointer, drop_cnt increments once, and the FSM goes to DISCARD, or to IDLE if the beat has tlast.
REQ-026 DISCARD SHALL write nothing and SHALL return to IDLE after the accepted tlast beat.
REQ-027 Pointers SHALL be DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1); usable capacity is 2^DEPTH_LOG2 - 1 beats.
REQ-028 Each stored entry SHALL hold tdata, tkeep and tlast (C_DATA_WIDTH+KEEP_WIDTH+1 bits).
REQ-029 The output SHALL be store-and-forward: eth_tx_tvalid is asserted only for beats below the commit pointer.
REQ-030 The first beat of a committed TLP SHALL appear on eth_tx_tvalid no more than 3 cycles after its tlast beat was accepted, given an empty output stage.
REQ-031 While eth_tx_tvalid=1 and eth_tx_tready=0, the eth_tx_tdata, eth_tx_tkeep and eth_tx_tlast outputs SHALL hold stable.
REQ-032 Once committed data is present, the output SHALL sustain one beat per cycle while eth_tx_tready=1.
REQ-033 A write and a read in the same cycle SHALL both take effect, and free space SHALL be computed from the registered read pointer.

Reset
REQ-034 While user_reset=1 at a user_clk edge, the FSM SHALL go to IDLE, all pointers SHALL be 0, and eth_tx_tvalid, eth_tx_tlast, pkt_cnt and drop_cnt SHALL be 0; tdata and tkeep are don't-care.
REQ-035 Reset asserted during a capture or a drain SHALL discard all buffered data, and the first accepted beat after reset SHALL be treated as SOP.

Verification
REQ-036 Send a 3-beat BAR4 TLP (tuser[6]=1) with tready=1 -> the same 3 beats appear in order on eth_tx within 3 cycles of tlast; pkt_cnt=1.
REQ-037 Send a 4-beat BAR0 TLP followed by a 2-beat BAR4 TLP -> only the 2 BAR4 beats are output; pkt_cnt=1; drop_cnt=0.
REQ-038 Hold eth_tx_tready=0 and send BAR4 TLPs of 8 beats each at DEPTH_LOG2=4 -> the first TLP (8 beats) commits, the second overflows and is dropped (drop_cnt=1), and releasing tready outputs exactly 8 beats.
REQ-039 Send a BAR4 TLP with tuser[1]=1 on beat 2 of 4 -> no output; drop_cnt=1; the next clean BAR4 TLP passes intact.
REQ-040 Toggle pcie_rx_tvalid on alternate cycles and eth_tx_tready randomly over 100 BAR4 TLPs -> data out matches data in beat for beat, with no loss and no duplicates.
REQ-041 Assert user_reset mid-CAPTURE with one committed TLP buffered -> eth_tx_tvalid=0 the next cycle, pkt_cnt=0 and drop_cnt=0, and a subsequent TLP is captured correctly.
